// File: rtl/apb_master_transfer_controller.sv
// apb_master_transfer_controller
// Turns one command at a time into a single APB SETUP/ACCESS transfer to the slave
// that the upper address bits select. It absorbs wait states, captures read data and
// slave errors, and aborts an ACCESS phase that waits too long. All outputs come
// straight from flops.
module apb_master_transfer_controller #(
    parameter int NO_OF_SLAVES   = 1,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int REGION_BITS    = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                               pclk,
    input  logic                               preset,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic                               cmd_write,
    input  logic [ADDR_WIDTH-1:0]              cmd_addr,
    input  logic [DATA_WIDTH-1:0]              cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]            cmd_strb,
    output logic                               rsp_valid,
    output logic [DATA_WIDTH-1:0]              rsp_rdata,
    output logic [1:0]                         rsp_err,
    output logic [NO_OF_SLAVES-1:0]            psel,
    output logic                               penable,
    output logic                               pwrite,
    output logic [ADDR_WIDTH-1:0]              paddr,
    output logic [DATA_WIDTH-1:0]              pwdata,
    output logic [DATA_WIDTH/8-1:0]            pstrb,
    input  logic [NO_OF_SLAVES*DATA_WIDTH-1:0] prdata,
    input  logic [NO_OF_SLAVES-1:0]            pready,
    input  logic [NO_OF_SLAVES-1:0]            pslverr
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0] LP_NSLV    = ADDR_WIDTH'(NO_OF_SLAVES);
    localparam logic [CNT_W-1:0]      LP_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    // Registered state and outputs
    logic [NO_OF_SLAVES-1:0] r_mask;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_cmd_ready;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic [1:0]              r_rsp_err;
    logic [NO_OF_SLAVES-1:0] r_psel;
    logic                    r_penable;
    logic                    r_pwrite;
    logic [ADDR_WIDTH-1:0]   r_paddr;
    logic [DATA_WIDTH-1:0]   r_pwdata;
    logic [STRB_W-1:0]       r_pstrb;

    // Next values for the registers above
    logic [NO_OF_SLAVES-1:0] w_mask_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    w_cmd_ready_nxt;
    logic                    w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]   w_rsp_rdata_nxt;
    logic [1:0]              w_rsp_err_nxt;
    logic [NO_OF_SLAVES-1:0] w_psel_nxt;
    logic                    w_penable_nxt;
    logic                    w_pwrite_nxt;
    logic [ADDR_WIDTH-1:0]   w_paddr_nxt;
    logic [DATA_WIDTH-1:0]   w_pwdata_nxt;
    logic [STRB_W-1:0]       w_pstrb_nxt;

    // Decode and selected-slave views
    logic                    w_accept;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic                    w_idx_ok;
    logic [NO_OF_SLAVES-1:0] w_mask_new;
    logic                    w_sel_ready;
    logic                    w_sel_err;
    logic [DATA_WIDTH-1:0]   w_sel_rdata;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic                    w_timeout;

    // cmd_ready is high exactly while IDLE, so it doubles as the accept qualifier
    assign w_accept    = cmd_valid & r_cmd_ready;
    assign w_idx       = cmd_addr >> REGION_BITS;
    assign w_idx_ok    = (w_idx < LP_NSLV);
    assign w_sel_ready = |(pready & r_mask);
    assign w_sel_err   = |(pslverr & r_mask);
    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    assign w_timeout   = (w_cnt_inc == LP_TIMEOUT);

    // One-hot target decode of the incoming address; all zero when out of range
    always_comb begin
        w_mask_new = '0;
        for (int i = 0; i < NO_OF_SLAVES; i++) begin
            w_mask_new[i] = (w_idx == ADDR_WIDTH'(i));
        end
    end

    // Read-data mux for the latched target; other slaves' buses are masked off
    always_comb begin
        w_sel_rdata = '0;
        for (int i = 0; i < NO_OF_SLAVES; i++) begin
            w_sel_rdata = w_sel_rdata | (prdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_mask[i]}});
        end
    end

    // State and output registers; reset drops the bus immediately
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state     <= ST_IDLE;
            r_mask      <= '0;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 2'd0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mask      <= w_mask_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_pstrb     <= w_pstrb_nxt;
        end
    end

    // Next-state logic: IDLE -> SETUP -> ACCESS -> RESP -> IDLE, decode errors skip the bus
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_idx_ok ? ST_SETUP : ST_RESP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (w_sel_ready || w_timeout) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: computes the next registered value of every bus/response output
    always_comb begin
        w_mask_nxt      = r_mask;
        w_cnt_nxt       = r_cnt;
        w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_pwrite_nxt    = r_pwrite;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_pstrb_nxt     = r_pstrb;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_mask_nxt   = w_mask_new;
                    w_paddr_nxt  = cmd_addr;
                    w_pwrite_nxt = cmd_write;
                    w_pwdata_nxt = cmd_wdata;
                    w_pstrb_nxt  = cmd_write ? cmd_strb : {STRB_W{1'b0}};
                    if (w_idx_ok) begin
                        w_psel_nxt = w_mask_new;
                    end else begin
                        w_psel_nxt      = '0;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 2'd2;
                        w_rsp_rdata_nxt = '0;
                    end
                end else begin
                    w_psel_nxt = '0;
                end
            end
            ST_SETUP: begin
                // Counter restarts every time ACCESS is entered
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = '0;
            end
            ST_ACCESS: begin
                if (w_sel_ready) begin
                    w_psel_nxt      = '0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = w_sel_err ? 2'd1 : 2'd0;
                    w_rsp_rdata_nxt = (r_pwrite || w_sel_err) ? {DATA_WIDTH{1'b0}} : w_sel_rdata;
                end else if (w_timeout) begin
                    w_cnt_nxt       = w_cnt_inc;
                    w_psel_nxt      = '0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 2'd3;
                    w_rsp_rdata_nxt = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_RESP: begin
                w_psel_nxt    = '0;
                w_penable_nxt = 1'b0;
            end
            default: begin
                w_psel_nxt    = '0;
                w_penable_nxt = 1'b0;
            end
        endcase
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign pstrb     = r_pstrb;

endmodule

// File: tb/tb_apb_master_transfer_controller.sv
// tb_apb_master_transfer_controller
// Transaction-level bench: each command is described by its target, wait-state count,
// error flag and read data; the expected bus/response timeline is derived from those.
module tb_apb_master_transfer_controller;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RB = 12;
    localparam int TO = 16;

    logic            pclk = 1'b0;
    logic            preset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic [DW/8-1:0] cmd_strb;
    logic            rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_err;
    logic [NS-1:0]   psel;
    logic            penable;
    logic            pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic [DW/8-1:0] pstrb;
    logic [NS*DW-1:0] prdata;
    logic [NS-1:0]   pready;
    logic [NS-1:0]   pslverr;

    int n_cmp = 0;
    int n_mis = 0;

    apb_master_transfer_controller #(
        .NO_OF_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .REGION_BITS(RB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Random noise on every slave; the target (if any) gets the scripted response
    task automatic drive_bus(input int target, input logic rdy, input logic e, input logic [DW-1:0] d);
        pready  = NS'($urandom);
        pslverr = NS'($urandom);
        for (int i = 0; i < NS; i++) prdata[i*DW +: DW] = $urandom;
        if (target >= 0 && target < NS) begin
            pready[target]          = rdy;
            pslverr[target]         = rdy ? e : 1'($urandom);
            prdata[target*DW +: DW] = d;
        end
    endtask

    task automatic scramble_cmd();
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
    endtask

    // One command from accept to the first IDLE cycle after its response
    task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [3:0] strb, input int waits, input logic serr,
                          input logic [DW-1:0] rdat);
        logic [AW-1:0] upper;
        int            idx;
        logic [NS-1:0] mask;
        int            nacc;
        logic [1:0]    exp_err;
        logic [DW-1:0] exp_rd;
        upper = addr >> RB;
        idx   = (upper < AW'(NS)) ? int'(upper) : -1;
        mask  = (idx >= 0) ? NS'(1 << idx) : '0;
        check("ready_before", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
        drive_bus(-1, 1'b0, 1'b0, '0);
        tick();
        cmd_valid = 1'b0;
        scramble_cmd();
        if (idx < 0) begin
            drive_bus(-1, 1'b0, 1'b0, '0);
            check("dec_valid", {63'd0, rsp_valid}, 64'd1);
            check("dec_err", {62'd0, rsp_err}, 64'd2);
            check("dec_rdata", {32'd0, rsp_rdata}, 64'd0);
            check("dec_psel", {60'd0, psel}, 64'd0);
            check("dec_ready", {63'd0, cmd_ready}, 64'd0);
            tick();
            check("dec_after_valid", {63'd0, rsp_valid}, 64'd0);
            check("dec_after_ready", {63'd0, cmd_ready}, 64'd1);
            return;
        end
        nacc    = (waits < TO) ? waits + 1 : TO;
        exp_err = (waits < TO) ? (serr ? 2'd1 : 2'd0) : 2'd3;
        exp_rd  = (waits < TO && !wr && !serr) ? rdat : '0;
        for (int c = 0; c <= nacc; c++) begin
            if (c == 0) drive_bus(-1, 1'b0, 1'b0, '0);
            else        drive_bus(idx, (c - 1) >= waits, serr, rdat);
            check("psel", {60'd0, psel}, {60'd0, mask});
            check("penable", {63'd0, penable}, (c > 0) ? 64'd1 : 64'd0);
            check("paddr", {32'd0, paddr}, {32'd0, addr});
            check("pwrite", {63'd0, pwrite}, {63'd0, wr});
            check("pstrb", {60'd0, pstrb}, wr ? {60'd0, strb} : 64'd0);
            if (wr) check("pwdata", {32'd0, pwdata}, {32'd0, wdata});
            check("busy_valid", {63'd0, rsp_valid}, 64'd0);
            check("busy_ready", {63'd0, cmd_ready}, 64'd0);
            tick();
        end
        drive_bus(-1, 1'b0, 1'b0, '0);
        check("rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("rsp_err", {62'd0, rsp_err}, {62'd0, exp_err});
        check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, exp_rd});
        check("resp_psel", {60'd0, psel}, 64'd0);
        check("resp_penable", {63'd0, penable}, 64'd0);
        check("resp_paddr", {32'd0, paddr}, {32'd0, addr});
        check("resp_pwrite", {63'd0, pwrite}, {63'd0, wr});
        check("resp_ready", {63'd0, cmd_ready}, 64'd0);
        tick();
        check("after_valid", {63'd0, rsp_valid}, 64'd0);
        check("after_ready", {63'd0, cmd_ready}, 64'd1);
        check("after_psel", {60'd0, psel}, 64'd0);
    endtask

    initial begin
        logic [AW-1:0] a;
        int            w;
        int            sidx;
        preset = 1'b1;
        cmd_valid = 1'b0;
        scramble_cmd();
        drive_bus(-1, 1'b0, 1'b0, '0);
        tick();
        tick();
        check("rst_psel", {60'd0, psel}, 64'd0);
        check("rst_penable", {63'd0, penable}, 64'd0);
        preset = 1'b0;
        tick();
        check("rst_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_err", {62'd0, rsp_err}, 64'd0);
        check("rst_rdata", {32'd0, rsp_rdata}, 64'd0);
        check("rst_paddr", {32'd0, paddr}, 64'd0);
        check("rst_pwrite", {63'd0, pwrite}, 64'd0);
        check("rst_pwdata", {32'd0, pwdata}, 64'd0);
        check("rst_pstrb", {60'd0, pstrb}, 64'd0);

        // Directed cases
        do_txn(1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 4'hF, 0, 1'b0, '0);
        do_txn(1'b0, 32'h0000_2004, '0, 4'h0, 3, 1'b0, 32'h1234_5678);
        do_txn(1'b1, 32'h0000_0020, 32'h0BAD_F00D, 4'h3, 1, 1'b1, '0);
        do_txn(1'b0, 32'h0000_5000, '0, 4'h0, 0, 1'b0, '0);
        do_txn(1'b0, 32'h0000_3000, '0, 4'h0, 40, 1'b0, 32'hDEAD_BEEF);
        do_txn(1'b0, 32'h0000_1FFC, '0, 4'h0, TO - 1, 1'b0, 32'hCAFE_0001);
        do_txn(1'b1, 32'h0000_1000, 32'h1111_2222, 4'hA, TO, 1'b0, '0);
        do_txn(1'b0, 32'hFFFF_F000, '0, 4'h0, 0, 1'b0, '0);
        do_txn(1'b0, 32'h0000_3FFC, '0, 4'h0, 2, 1'b1, 32'h5555_AAAA);

        // Randomized commands
        for (int t = 0; t < 60; t++) begin
            sidx = $urandom_range(0, 5);
            a    = (AW'(sidx) << RB) | AW'($urandom_range(0, 4095));
            case ($urandom_range(0, 9))
                0:       w = TO;
                1:       w = TO - 1;
                2:       w = $urandom_range(TO + 1, TO + 6);
                default: w = $urandom_range(0, 5);
            endcase
            do_txn(1'($urandom), a, $urandom, 4'($urandom), w, ($urandom_range(0, 3) == 0), $urandom);
        end

        // Reset raised one cycle into ACCESS
        check("mid_ready0", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_1000;
        drive_bus(1, 1'b0, 1'b0, '0);
        tick();
        cmd_valid = 1'b0;
        drive_bus(1, 1'b0, 1'b0, '0);
        tick();
        check("mid_penable_pre", {63'd0, penable}, 64'd1);
        preset = 1'b1;
        #1;
        check("mid_psel", {60'd0, psel}, 64'd0);
        check("mid_penable", {63'd0, penable}, 64'd0);
        check("mid_valid", {63'd0, rsp_valid}, 64'd0);
        tick();
        preset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_bus(1, 1'b1, 1'b0, '0);
            tick();
            check("post_rst_valid", {63'd0, rsp_valid}, 64'd0);
            check("post_rst_ready", {63'd0, cmd_ready}, 64'd1);
            check("post_rst_psel", {60'd0, psel}, 64'd0);
        end
        do_txn(1'b0, 32'h0000_2008, '0, 4'h0, 0, 1'b0, 32'h0F0F_F0F0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
